sim_periph_bridge: RTL and testbench

//   Single-outstanding AXI slave that sits between the core's M_AXI master and the

---
 rtl/sim_periph_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_sim_periph_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_periph_bridge.sv
// AXI slave bridge from the core's M_AXI port to the simulation peripherals.
// One transaction in flight; round-robin read/write arbitration; one-hot peripheral request with timeout.
module sim_periph_bridge #(
  parameter logic [23:0] UART_BASE   = 24'h9a1000,
  parameter logic [23:0] SD_BASE     = 24'h9a1010,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [1:0]  p_req,
  output logic        p_we,
  output logic [31:0] p_addr,
  output logic [3:0]  p_be,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata0,
  input  logic [31:0] p_rdata1,
  input  logic [1:0]  p_rvalid
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Last WAIT count before timeout, so the SLVERR response lands TIMEOUT_CYC cycles after p_req.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic             rr_wr;
  logic             is_rd;
  logic             sel;
  logic [CNT_W-1:0] cnt;

  logic        wr_pend;
  logic        grant_rd;
  logic        grant_wr;
  logic        accept;
  logic [31:0] acc_addr;
  logic        hit0;
  logic        hit1;
  logic        len_bad;
  logic        acc_err;
  logic [1:0]  acc_resp;
  logic        slv_done;
  logic        slv_timeout;
  logic [1:0]  fin_resp;
  logic [31:0] fin_data;
  logic        resp_hs;

  assign wr_pend       = S_AXI_AWVALID & S_AXI_WVALID;
  assign S_AXI_ARREADY = grant_rd;
  assign S_AXI_AWREADY = grant_wr;
  assign S_AXI_WREADY  = grant_wr;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = acc_err ? S_RESP : S_REQ;
      S_REQ:  state_nx = slv_done ? S_RESP : S_WAIT;
      S_WAIT: if (slv_done || slv_timeout) state_nx = S_RESP;
      S_RESP: if (resp_hs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Arbitration, decode, completion and handshake strobes
  always_comb begin
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    slv_done    = 1'b0;
    slv_timeout = 1'b0;
    resp_hs     = 1'b0;
    acc_addr    = S_AXI_ARADDR;
    hit0        = 1'b0;
    hit1        = 1'b0;
    len_bad     = 1'b0;
    acc_err     = 1'b0;
    acc_resp    = RESP_OKAY;
    fin_resp    = RESP_OKAY;
    fin_data    = '0;
    case (state)
      S_IDLE: begin
        if (resetn) begin
          grant_rd = S_AXI_ARVALID & (~wr_pend | ~rr_wr);
          grant_wr = wr_pend & (~S_AXI_ARVALID | rr_wr);
        end
      end
      S_REQ:  slv_done = p_rvalid[sel];
      S_WAIT: begin
        slv_done    = p_rvalid[sel];
        slv_timeout = ~p_rvalid[sel] & (cnt == CNT_LAST);
      end
      S_RESP: resp_hs = is_rd ? (S_AXI_RVALID & S_AXI_RREADY)
                              : (S_AXI_BVALID & S_AXI_BREADY);
      default: ;
    endcase
    accept = grant_rd | grant_wr;
    if (grant_wr) begin
      acc_addr = S_AXI_AWADDR;
      len_bad  = (S_AXI_AWLEN != 8'd0) | ~S_AXI_WLAST;
    end else begin
      len_bad  = (S_AXI_ARLEN != 8'd0);
    end
    hit0 = (acc_addr[31:8] == UART_BASE);
    hit1 = (acc_addr[31:8] == SD_BASE);
    if (len_bad) begin
      acc_err  = 1'b1;
      acc_resp = RESP_SLVERR;
    end else if (!hit0 && !hit1) begin
      acc_err  = 1'b1;
      acc_resp = RESP_DECERR;
    end
    if (slv_done) fin_data = sel ? p_rdata1 : p_rdata0;
    else          fin_resp = RESP_SLVERR;
  end

  // Transaction bookkeeping: arbitration pointer, direction, target, timeout counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_wr <= 1'b0;
      is_rd <= 1'b0;
      sel   <= 1'b0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        rr_wr <= grant_rd;
        is_rd <= grant_rd;
        sel   <= hit1;
      end
      if (state == S_REQ)       cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

  // Peripheral request side; p_req is a one-cycle pulse, the rest holds until the next accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_req   <= '0;
      p_we    <= 1'b0;
      p_addr  <= '0;
      p_be    <= '0;
      p_wdata <= '0;
    end else begin
      p_req <= '0;
      if (accept) begin
        if (!acc_err) p_req <= hit1 ? 2'b10 : 2'b01;
        p_we   <= grant_wr;
        p_addr <= acc_addr;
        p_be   <= grant_wr ? S_AXI_WSTRB : 4'hF;
        if (grant_wr) p_wdata <= S_AXI_WDATA;
      end
    end
  end

  // AXI response channels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RLAST  <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= '0;
    end else if (accept && acc_err) begin
      if (grant_rd) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RLAST  <= 1'b1;
        S_AXI_RDATA  <= '0;
        S_AXI_RRESP  <= acc_resp;
      end else begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= acc_resp;
      end
    end else if (slv_done || slv_timeout) begin
      if (is_rd) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RLAST  <= 1'b1;
        S_AXI_RDATA  <= fin_data;
        S_AXI_RRESP  <= fin_resp;
      end else begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= fin_resp;
      end
    end else if (resp_hs) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RLAST  <= 1'b0;
      S_AXI_BVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sim_periph_bridge.sv
// Scoreboard bench for sim_periph_bridge: directed AXI traffic, a small peripheral responder,
// and a monitor that checks peripheral requests and AXI responses against queued expectations.
module tb_sim_periph_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [1:0]  p_req, p_rvalid;
  logic        p_we;
  logic [31:0] p_addr, p_wdata, p_rdata0, p_rdata1;
  logic [3:0]  p_be;

  sim_periph_bridge dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_be(p_be), .p_wdata(p_wdata),
    .p_rdata0(p_rdata0), .p_rdata1(p_rdata1), .p_rvalid(p_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat_acc;
    int          lat_req;
  } rsp_t;

  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } preq_t;

  rsp_t  eq[$];
  preq_t pq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0, preq_cyc = 0, rise_cyc = 0;
  bit rv_prev = 1'b0, bv_prev = 1'b0;

  int          slv_delay = 1;
  bit          slv_wrong = 1'b0;
  logic [1:0]  slv_r;
  logic [31:0] slv_d0 = 32'h0000_0041;
  logic [31:0] slv_d1 = 32'h0;
  assign p_rdata0 = slv_d0;
  assign p_rdata1 = slv_d1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic exp_rsp(input bit rd, input logic [31:0] d, input logic [1:0] r,
                         input int la, input int lr);
    rsp_t e;
    e.is_rd = rd; e.data = d; e.resp = r; e.lat_acc = la; e.lat_req = lr;
    eq.push_back(e);
  endtask

  task automatic exp_req(input logic [1:0] rq, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    preq_t e;
    e.req = rq; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
    pq.push_back(e);
  endtask

  // Peripheral responder: strobes p_rvalid slv_delay cycles after p_req (0 = same cycle, <0 = never)
  always begin
    @(negedge clk);
    if (resetn && p_req != 2'b00 && slv_delay >= 0) begin
      slv_r = p_req;
      if (slv_delay == 0) begin
        p_rvalid = slv_r;
        @(posedge clk); #1 p_rvalid = 2'b00;
      end else begin
        for (int k = 1; k <= slv_delay; k++) begin
          @(posedge clk); #1;
          if (k == slv_delay)            p_rvalid = slv_r;
          else if (slv_wrong && k == 1)  p_rvalid = ~slv_r;
          else                           p_rvalid = 2'b00;
        end
        @(posedge clk); #1 p_rvalid = 2'b00;
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a request or a response
  always @(negedge clk) begin
    if (!resetn) begin
      rv_prev = 1'b0;
      bv_prev = 1'b0;
    end else begin
      if ((S_AXI_ARVALID && S_AXI_ARREADY) || (S_AXI_AWVALID && S_AXI_AWREADY)) acc_cyc = cyc;
      if (p_req != 2'b00) begin
        preq_cyc = cyc;
        if (pq.size() == 0) fail_now("unexpected_p_req");
        else begin
          preq_t e;
          e = pq.pop_front();
          chk("p_req", 32'(p_req), 32'(e.req));
          chk("p_we", 32'(p_we), 32'(e.we));
          chk("p_addr", p_addr, e.addr);
          chk("p_be", 32'(p_be), 32'(e.be));
          if (e.we) chk("p_wdata", p_wdata, e.wdata);
        end
      end
      if ((S_AXI_RVALID && !rv_prev) || (S_AXI_BVALID && !bv_prev)) rise_cyc = cyc;
      if (S_AXI_RVALID || S_AXI_BVALID) begin
        if (eq.size() == 0) fail_now("unexpected_response");
        else begin
          rsp_t e;
          bit hs;
          e = eq[0];
          chk("resp_is_read", 32'(S_AXI_RVALID), 32'(e.is_rd));
          chk("resp_single_channel", 32'(S_AXI_RVALID & S_AXI_BVALID), 32'd0);
          if (S_AXI_RVALID) begin
            chk("rdata", S_AXI_RDATA, e.data);
            chk("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
            chk("rlast", 32'(S_AXI_RLAST), 32'd1);
          end else begin
            chk("bresp", 32'(S_AXI_BRESP), 32'(e.resp));
          end
          hs = (S_AXI_RVALID && S_AXI_RREADY) || (S_AXI_BVALID && S_AXI_BREADY);
          if (hs) begin
            if (e.lat_acc >= 0) chk("lat_from_accept", 32'(rise_cyc - acc_cyc), 32'(e.lat_acc));
            if (e.lat_req >= 0) chk("lat_from_p_req", 32'(rise_cyc - preq_cyc), 32'(e.lat_req));
            void'(eq.pop_front());
          end
        end
      end
      rv_prev = S_AXI_RVALID;
      bv_prev = S_AXI_BVALID;
    end
  end

  task automatic drive_ar(input logic [31:0] a, input logic [7:0] len);
    int n;
    @(posedge clk); #1;
    S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARVALID = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (S_AXI_ARREADY) break;
      n++;
      if (n > 200) begin fail_now("arready_timeout"); break; end
    end
    @(posedge clk); #1 S_AXI_ARVALID = 1'b0;
  endtask

  task automatic drive_aw_w(input logic [31:0] a, input logic [7:0] len, input logic [31:0] d,
                            input logic [3:0] strb, input logic last);
    int n;
    @(posedge clk); #1;
    S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = strb; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (S_AXI_AWREADY) begin
        chk("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
        break;
      end
      n++;
      if (n > 200) begin fail_now("awready_timeout"); break; end
    end
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (eq.size() != 0 || pq.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin fail_now("scoreboard_drain_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_rlast", 32'(S_AXI_RLAST), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
    chk("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
    chk("rst_p_req", 32'(p_req), 32'd0);
    chk("rst_p_we", 32'(p_we), 32'd0);
    chk("rst_p_addr", p_addr, 32'd0);
    chk("rst_p_be", 32'(p_be), 32'd0);
    chk("rst_p_wdata", p_wdata, 32'd0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    p_rvalid = 2'b00;
    #1 chk_reset_outs();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic read to uart: response 3 cycles after accept, 2 after p_req
    exp_req(2'b01, 1'b0, 32'h9a10_0004, 4'hF, 32'h0);
    exp_rsp(1'b1, 32'h0000_0041, 2'b00, 3, 2);
    drive_ar(32'h9a10_0004, 8'd0);
    wait_idle();

    // Write to sd
    exp_req(2'b10, 1'b1, 32'h9a10_1000, 4'h1, 32'h0000_1234);
    exp_rsp(1'b0, 32'h0, 2'b00, 3, 2);
    drive_aw_w(32'h9a10_1000, 8'd0, 32'h0000_1234, 4'h1, 1'b1);
    wait_idle();

    // Error responses: no p_req, response one cycle after accept
    exp_rsp(1'b1, 32'h0, 2'b11, 1, -1);
    drive_ar(32'h8000_0000, 8'd0);
    wait_idle();
    exp_rsp(1'b1, 32'h0, 2'b10, 1, -1);
    drive_ar(32'h9a10_0000, 8'd3);
    wait_idle();
    exp_rsp(1'b0, 32'h0, 2'b10, 1, -1);
    drive_aw_w(32'h9a10_0000, 8'd0, 32'hdead_beef, 4'hF, 1'b0);
    wait_idle();
    exp_rsp(1'b0, 32'h0, 2'b11, 1, -1);
    drive_aw_w(32'h1234_5600, 8'd0, 32'hdead_beef, 4'hF, 1'b1);
    wait_idle();

    // Zero-wait sd slave: p_rvalid during the request cycle
    slv_delay = 0;
    slv_d1 = 32'hcafe_0001;
    exp_req(2'b10, 1'b0, 32'h9a10_1004, 4'hF, 32'h0);
    exp_rsp(1'b1, 32'hcafe_0001, 2'b00, 2, 1);
    drive_ar(32'h9a10_1004, 8'd0);
    wait_idle();

    // Strobe from the non-selected slave is ignored; real one arrives 3 cycles after p_req
    slv_delay = 3;
    slv_wrong = 1'b1;
    exp_req(2'b01, 1'b0, 32'h9a10_0008, 4'hF, 32'h0);
    exp_rsp(1'b1, 32'h0000_0041, 2'b00, 5, 4);
    drive_ar(32'h9a10_0008, 8'd0);
    wait_idle();
    slv_wrong = 1'b0;

    // Timeout, then RREADY held low for 5 cycles with data checked stable
    slv_delay = -1;
    S_AXI_RREADY = 1'b0;
    exp_req(2'b01, 1'b0, 32'h9a10_0010, 4'hF, 32'h0);
    exp_rsp(1'b1, 32'h0, 2'b10, -1, 16);
    drive_ar(32'h9a10_0010, 8'd0);
    n = 0;
    while (!S_AXI_RVALID) begin
      @(negedge clk);
      n++;
      if (n > 40) begin fail_now("timeout_rvalid_wait"); break; end
    end
    repeat (5) @(posedge clk);
    #1 S_AXI_RREADY = 1'b1;
    wait_idle();

    // Arbitration after reset: AW without W is never accepted, then R/W pairs alternate
    apply_reset();
    slv_delay = 1;
    @(posedge clk); #1;
    S_AXI_AWADDR = 32'h9a10_1000; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("awready_without_w", 32'(S_AXI_AWREADY), 32'd0);
    end
    @(posedge clk); #1 S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_req(2'b01, 1'b0, 32'h9a10_0000 + 32'(16 * i), 4'hF, 32'h0);
      exp_rsp(1'b1, 32'h0000_0041, 2'b00, 3, 2);
      exp_req(2'b10, 1'b1, 32'h9a10_1000 + 32'(4 * i), 4'h3, 32'h0000_5500 + 32'(i));
      exp_rsp(1'b0, 32'h0, 2'b00, 3, 2);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) drive_ar(32'h9a10_0000 + 32'(16 * i), 8'd0);
      end
      begin
        for (int j = 0; j < 4; j++)
          drive_aw_w(32'h9a10_1000 + 32'(4 * j), 8'd0, 32'h0000_5500 + 32'(j), 4'h3, 1'b1);
      end
    join
    wait_idle();

    // Reset while waiting on a silent slave: outputs clear at once, no late response
    slv_delay = -1;
    exp_req(2'b01, 1'b0, 32'h9a10_0000, 4'hF, 32'h0);
    exp_rsp(1'b1, 32'h0, 2'b10, -1, -1);
    drive_ar(32'h9a10_0000, 8'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1 chk_reset_outs();
    eq.delete();
    pq.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    slv_delay = 1;
    exp_req(2'b01, 1'b0, 32'h9a10_0000, 4'hF, 32'h0);
    exp_rsp(1'b1, 32'h0000_0041, 2'b00, 3, 2);
    drive_ar(32'h9a10_0000, 8'd0);
    wait_idle();

    repeat (5) @(posedge clk);
    chk("resp_queue_empty", 32'(eq.size()), 32'd0);
    chk("req_queue_empty", 32'(pq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
